// File: rtl/tohost_monitor.sv
// tohost_monitor: end-of-test monitor snooping CPU data-memory stores for the riscv-tests
// `tohost` word. It decodes pass/fail and keeps cycle and retired-instruction counters for the
// RUN window. An optional watchdog ends a run that never writes tohost.
//
// Optional feature macro: TOHOST_WATCHDOG_EN. When defined, a RUN that lasts TIMEOUT_CYCLES
// cycles without a terminating store ends in TIMEOUT. When undefined, TIMEOUT is unreachable
// and timeout is tied low.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, clear        single-cycle control pulses (clear wins over everything)
//   dmem_addr/wdata/we/be  snooped CPU store port
//   retire              one instruction retired this cycle
//   state               IDLE=0 RUN=1 PASS=2 FAIL=3 TIMEOUT=4
//   done/pass/fail/timeout  registered status flags
//   fail_code           tohost value >> 1 from a failing store
//   cycle_count, instret_count  saturating RUN-window counters
module tohost_monitor #(
  parameter int unsigned       ALEN           = 32,
  parameter int unsigned       XLEN           = 32,
  parameter logic [ALEN-1:0]   TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned       TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned       CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic [ALEN-1:0]      dmem_addr,
  input  logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_we,
  input  logic [3:0]           dmem_be,
  input  logic                 retire,
  output logic [2:0]           state,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [XLEN-2:0]      fail_code,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StPass    = 3'd2,
    StFail    = 3'd3,
    StTimeout = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [XLEN-1:0]      PassVal = XLEN'(1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]   instret_q, instret_d;
  logic [XLEN-2:0]        fail_code_q, fail_code_d;
  logic                   done_q, pass_q, fail_q;
  logic                   tohost_wr;

  // Full-word store to tohost; RUN qualification is applied in the state decode.
  assign tohost_wr = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_be == 4'b1111);

`ifdef TOHOST_WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    instret_d   = instret_q;
    fail_code_d = fail_code_q;
    if (clear) begin
      state_d     = StIdle;
      cycle_d     = '0;
      instret_d   = '0;
      fail_code_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StRun;
            cycle_d   = '0;
            instret_d = '0;
          end
        end
        StRun: begin
          // The terminating cycle is itself a RUN cycle, so it is counted.
          if (cycle_q != CntMax) cycle_d = cycle_q + CntOne;
          if (retire && (instret_q != CntMax)) instret_d = instret_q + CntOne;
          if (tohost_wr && (dmem_wdata == PassVal)) begin
            state_d = StPass;
          end else if (tohost_wr && dmem_wdata[0]) begin
            state_d     = StFail;
            fail_code_d = dmem_wdata[XLEN-1:1];
`ifdef TOHOST_WATCHDOG_EN
          end else if (cycle_q == TimeoutLast) begin
            state_d = StTimeout;
`endif
          end
        end
        default: ;  // terminal states hold until clear or reset
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cycle_q     <= '0;
      instret_q   <= '0;
      fail_code_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      fail_code_q <= fail_code_d;
      done_q      <= (state_d == StPass) || (state_d == StFail) || (state_d == StTimeout);
      pass_q      <= (state_d == StPass);
      fail_q      <= (state_d == StFail);
    end
  end

`ifdef TOHOST_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= (state_d == StTimeout);
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign state         = state_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign fail_code     = fail_code_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_tohost_monitor.sv
module tb_tohost_monitor;

  localparam logic [31:0] Tohost = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic        retire;
  logic [2:0]  state;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  int n_checks = 0;
  int n_passed = 0;

  tohost_monitor #(
    .ALEN          (32),
    .XLEN          (32),
    .TOHOST_ADDR   (Tohost),
    .TIMEOUT_CYCLES(20),
    .CNT_WIDTH     (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .dmem_be      (dmem_be),
    .retire       (retire),
    .state        (state),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_code    (fail_code),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    dmem_addr  = addr;
    dmem_wdata = data;
    dmem_be    = be;
    dmem_we    = 1'b1;
    step();
    dmem_we    = 1'b0;
    dmem_be    = 4'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; retire = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0; dmem_be = '0;
    step(); step();
    check("rst_state", state, 0);
    check("rst_flags", {done, pass, fail, timeout}, 0);
    check("rst_counts", {fail_code, cycle_count, instret_count}, 0);
    rst_n = 1'b1;
    step();

    // Pass after 11 RUN cycles, retire every cycle
    pulse_start();
    check("start_state", state, 1);
    check("start_cycle0", cycle_count, 0);
    retire = 1'b1;
    step();
    check("run_cycle1", cycle_count, 1);
    repeat (9) step();
    store(Tohost, 32'h1, 4'hF);
    check("pass_flags", {done, pass, fail, timeout}, 4'b1100);
    check("pass_state", state, 2);
    check("pass_cycles", cycle_count, 11);
    check("pass_instret", instret_count, 11);
    store(Tohost, 32'h7, 4'hF);
    step();
    check("pass_hold", state, 2);
    check("pass_freeze", {cycle_count, instret_count}, {32'd11, 32'd11});
    retire = 1'b0;
    pulse_clear();
    check("clear_state", state, 0);
    check("clear_counts", {done, fail_code, cycle_count, instret_count}, 0);

    // Fail decode
    pulse_start();
    store(Tohost, 32'h0000_0007, 4'hF);
    check("fail_state", state, 3);
    check("fail_flags", {done, pass, fail, timeout}, 4'b1010);
    check("fail_code", fail_code, 3);
    store(Tohost, 32'h1, 4'hF);
    check("fail_hold", state, 3);
    check("fail_code_hold", fail_code, 3);
    pulse_clear();
    check("fail_clear", {state, fail_code}, 0);

    // Non-terminating stores
    pulse_start();
    store(Tohost, 32'h2, 4'hF);
    check("even_ignored", state, 1);
    store(Tohost, 32'h1, 4'h1);
    check("partial_ignored", state, 1);
    store(Tohost + 32'd4, 32'h1, 4'hF);
    check("addr_ignored", state, 1);
    store(Tohost, 32'h1, 4'hF);
    check("late_pass", {state, pass}, {3'd2, 1'b1});
    check("late_pass_cycles", cycle_count, 4);
    pulse_clear();

    // Watchdog with TIMEOUT_CYCLES=20
    pulse_start();
    repeat (19) step();
    check("wd_pre_state", state, 1);
    check("wd_pre_cycles", cycle_count, 19);
    step();
`ifdef TOHOST_WATCHDOG_EN
    check("wd_state", state, 4);
    check("wd_flags", {done, pass, fail, timeout}, 4'b1001);
    check("wd_cycles", cycle_count, 20);
    repeat (3) step();
    check("wd_freeze", cycle_count, 20);
    pulse_clear();
    pulse_start();
    repeat (19) step();
    store(Tohost, 32'h1, 4'hF);
    check("wd_race_state", state, 2);
    check("wd_race_flags", {pass, timeout}, 2'b10);
    check("wd_race_cycles", cycle_count, 20);
`else
    check("nowd_state", state, 1);
    check("nowd_flags", {done, timeout}, 0);
    repeat (5) step();
    check("nowd_cycles", cycle_count, 25);
    store(Tohost, 32'h1, 4'hF);
    check("nowd_pass", state, 2);
`endif
    pulse_clear();

    // IDLE ignores stores; clear beats start
    store(Tohost, 32'h1, 4'hF);
    check("idle_store", {state, done}, 0);
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    check("start_clear", state, 0);
    step();
    check("start_clear_hold", state, 0);

    // Asynchronous reset mid-RUN
    pulse_start();
    retire = 1'b1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_outputs", {done, pass, fail, timeout, fail_code, cycle_count, instret_count}, 0);
    retire = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    pulse_start();
    check("rerun_start", {state, cycle_count, instret_count}, {3'd1, 32'd0, 32'd0});
    retire = 1'b1;
    step();
    retire = 1'b0;
    check("rerun_counts", {cycle_count, instret_count}, {32'd1, 32'd1});

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Synthesizable end-of-test monitor that sits directly downstream of the CPU's data-memory port, in parallel with data memory. It snoops store traffic for the riscv-tests `tohost` word, decodes pass/fail, and runs a cycle watchdog. It also keeps cycle and retired-instruction counters. Its status outputs are the completion signal a simulation bench waits on and the pass/fail indicator an FPGA build drives to LEDs.

## Interface
Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the `tohost` word; ALEN bits, word-aligned.
- TIMEOUT_CYCLES, 5_000_000, watchdog limit in clk cycles spent in RUN.
- CNT_WIDTH, 32, width of both counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; moves the block from IDLE to RUN.
- clear  in  1  single-cycle pulse; returns the block to IDLE from any state.
- dmem_addr  in  ALEN  CPU data-memory address.
- dmem_wdata  in  XLEN  CPU store data.
- dmem_we  in  1  CPU store strobe.
- dmem_be  in  4  CPU byte enables.
- retire  in  1  one instruction retired this cycle.
- state  out  3  current state: IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- timeout  out  1  high in TIMEOUT.
- fail_code  out  XLEN-1  failing test number, equal to the tohost value >> 1.
- cycle_count  out  CNT_WIDTH  cycles spent in RUN.
- instret_count  out  CNT_WIDTH  retire pulses counted in RUN.

## Operation
- Reset: state=IDLE. done, pass, fail and timeout are 0. fail_code, cycle_count and instret_count are 0.
- Qualifying write: all of the following in the same cycle:
  - state==RUN
  - dmem_we=1
  - dmem_addr==TOHOST_ADDR
  - dmem_be==4'b1111
- Partial-byte writes to TOHOST_ADDR are ignored.
- Decode of a qualifying write with value v:
  - v==1 goes to PASS.
  - v[0]==1 and v!=1 goes to FAIL, with fail_code latched as v>>1.
  - v[0]==0 (including v==0) is ignored and the block stays in RUN.
- IDLE: start goes to RUN. Both counters clear to 0 on that edge. Stores are ignored.
- RUN:
  - cycle_count increments every cycle.
  - instret_count increments when retire=1.
  - start is ignored.
- Terminal states (PASS, FAIL, TIMEOUT):
  - Counters and fail_code freeze.
  - Further stores and start are ignored.
  - Only clear or reset leaves a terminal state.
- clear has priority over every other event. It returns the block to IDLE and zeroes fail_code and both counters.
- Counters saturate at all-ones and never wrap.
- Simultaneous events:
  - A qualifying write in the watchdog-expiry cycle wins: the block goes to PASS or FAIL, not TIMEOUT.
  - A retire in the same cycle as the terminating write is counted.
- Reset asserted mid-RUN forces IDLE immediately (asynchronous). All outputs read 0 before the next edge.

## Timing
- Every output is registered. No output has a combinational path from an input.
- A qualifying write sampled at edge N makes state, done, pass/fail and fail_code valid after edge N, in cycle N+1.
- start sampled at edge N gives state=RUN and cycle_count=0 in cycle N+1, and cycle_count=1 in cycle N+2.
- cycle_count in a terminal state equals the number of RUN cycles, including the terminating cycle.
- Watchdog: TIMEOUT is entered on the edge where cycle_count==TIMEOUT_CYCLES-1 and no qualifying write is present. cycle_count then freezes at TIMEOUT_CYCLES.

## Configuration
- TOHOST_WATCHDOG_EN defined: the watchdog is compiled in as described above.
- TOHOST_WATCHDOG_EN undefined:
  - No timeout compare logic is built, and the TIMEOUT state is unreachable.
  - timeout is tied to 0.
  - RUN lasts until a qualifying write or clear.
  - cycle_count saturates at all-ones.

## Test plan
- Reset, start, 10 cycles with retire=1 every cycle, then store 32'h1 to TOHOST_ADDR with be=4'hF -> pass=1 and done=1 in the next cycle, state=2, cycle_count=11, instret_count=11.
- RUN, store 32'h0000_0007 -> fail=1, fail_code=3, state=3; a following store of 32'h1 leaves the block in FAIL.
- RUN, store 32'h2, then 32'h1 with be=4'h1, then 32'h1 to TOHOST_ADDR+4 -> none terminate, state stays 1; then a full store of 32'h1 -> PASS.
- TOHOST_WATCHDOG_EN, TIMEOUT_CYCLES=20, no stores -> timeout=1 after exactly 20 RUN cycles, cycle_count=20; repeat with store 32'h1 in cycle 20 -> PASS, timeout=0.
- Store 32'h1 while in IDLE -> ignored, state=0; start and clear in the same cycle -> state stays 0.
- Deassert rst_n mid-RUN, between clock edges -> all outputs 0 and state=0 before the next edge; after release, start runs normally with counters from 0.
